pll_lock_sequencer: RTL and testbench

Reset and lock controller for the three-output system PLL (40 MHz, 25 MHz, 0.8 MHz) of the DSO.

- Runs on the free-running 50 MHz reference clock.
- Pulses the PLL reset, then qualifies the lock indication.
- Releases the per-clock-domain resets in a fixed staggered order.
- Supervises lock after release: re-sequences on lock loss and latches a fault after repeated lock timeouts.

---
 rtl/pll_lock_sequencer.sv | 148 ++++++++++++++
 tb/tb_pll_lock_sequencer.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: PLL reset pulse, lock qualification, staggered domain reset release and lock supervision
module pll_lock_sequencer #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int STAGGER_CYCLES      = 64,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       refclk_i,
    input  logic       rst_i,
    input  logic       pll_locked_i,
    input  logic       relock_req_i,
    output logic       pll_rst_o,
    output logic [2:0] dom_rst_o,
    output logic       clk_ok_o,
    output logic       fault_o,
    output logic [2:0] retry_cnt_o,
    output logic [7:0] lol_cnt_o,
    output logic [2:0] state_o
);
    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RELEASE   = 3'd3,
        RUN       = 3'd4,
        FAULT     = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] RST_LD = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LD  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LD  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SG_LD  = CNT_W'(STAGGER_CYCLES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       dom_q, dom_d;
    logic [2:0]       retry_q, retry_d;
    logic [7:0]       lol_q, lol_d;
    logic             pll_rst_q, clk_ok_q, fault_q;
    logic             sync1_q, lock_s_q;
    logic             zero;

    assign zero        = cnt_q == '0;
    assign pll_rst_o   = pll_rst_q;
    assign dom_rst_o   = dom_q;
    assign clk_ok_o    = clk_ok_q;
    assign fault_o     = fault_q;
    assign retry_cnt_o = retry_q;
    assign lol_cnt_o   = lol_q;
    assign state_o     = state_q;

    // Next state; outputs are derived from the next state so they register together with it
    always_comb begin
        state_d = state_q;
        cnt_d   = zero ? '0 : cnt_q - 1'b1;
        dom_d   = dom_q;
        retry_d = retry_q;
        lol_d   = lol_q;
        case (state_q)
            RESET_PLL: if (zero) begin
                state_d = WAIT_LOCK;
                cnt_d   = TO_LD;
            end
            WAIT_LOCK: if (lock_s_q) begin
                state_d = STABLE;
                cnt_d   = ST_LD;
            end else if (zero) begin
                if (retry_q < 3'(MAX_RETRIES)) begin
                    retry_d = retry_q + 3'd1;
                    state_d = RESET_PLL;
                    cnt_d   = RST_LD;
                end else begin
                    state_d = FAULT;
                end
            end
            STABLE: if (!lock_s_q) begin
                state_d = WAIT_LOCK;
                cnt_d   = TO_LD;
            end else if (zero) begin
                state_d = RELEASE;
                cnt_d   = SG_LD;
                dom_d   = 3'b110;
            end
            // dom_q itself tracks which release step comes next
            RELEASE: if (!lock_s_q) begin
                state_d = RESET_PLL;
                cnt_d   = RST_LD;
            end else if (zero) begin
                if (dom_q[1]) begin
                    dom_d = 3'b100;
                    cnt_d = SG_LD;
                end else if (dom_q[2]) begin
                    dom_d = 3'b000;
                    cnt_d = '0;
                end else begin
                    state_d = RUN;
                end
            end
            RUN: if (!lock_s_q) begin
                state_d = RESET_PLL;
                cnt_d   = RST_LD;
                retry_d = '0;
                lol_d   = (lol_q != 8'hff) ? lol_q + 8'd1 : lol_q;
            end
            FAULT: ;
            default: begin
                state_d = RESET_PLL;
                cnt_d   = RST_LD;
            end
        endcase
        if (relock_req_i && state_q != RESET_PLL) begin
            state_d = RESET_PLL;
            cnt_d   = RST_LD;
            retry_d = '0;
        end
        if (state_d == RESET_PLL || state_d == FAULT)
            dom_d = 3'b111;
    end

    // State, counter, synchronizer and registered outputs
    always_ff @(posedge refclk_i) begin
        if (rst_i) begin
            state_q   <= RESET_PLL;
            cnt_q     <= RST_LD;
            dom_q     <= 3'b111;
            retry_q   <= '0;
            lol_q     <= '0;
            pll_rst_q <= 1'b1;
            clk_ok_q  <= 1'b0;
            fault_q   <= 1'b0;
            sync1_q   <= 1'b0;
            lock_s_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dom_q     <= dom_d;
            retry_q   <= retry_d;
            lol_q     <= lol_d;
            pll_rst_q <= state_d == RESET_PLL || state_d == FAULT;
            clk_ok_q  <= state_d == RUN;
            fault_q   <= state_d == FAULT;
            sync1_q   <= pll_locked_i;
            lock_s_q  <= sync1_q;
        end
    end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: table-driven bring-up plus directed corner sequences for pll_lock_sequencer
module tb_pll_lock_sequencer;
    logic       refclk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_locked = 1'b0;
    logic       relock_req = 1'b0;
    logic       pll_rst;
    logic [2:0] dom_rst;
    logic       clk_ok;
    logic       fault;
    logic [2:0] retry_cnt;
    logic [7:0] lol_cnt;
    logic [2:0] state;

    int checks = 0;
    int failures = 0;

    pll_lock_sequencer #(
        .RST_PULSE_CYCLES(4),
        .LOCK_TIMEOUT_CYCLES(20),
        .LOCK_STABLE_CYCLES(8),
        .STAGGER_CYCLES(2),
        .MAX_RETRIES(2),
        .CNT_W(16)
    ) dut (
        .refclk_i(refclk),
        .rst_i(rst),
        .pll_locked_i(pll_locked),
        .relock_req_i(relock_req),
        .pll_rst_o(pll_rst),
        .dom_rst_o(dom_rst),
        .clk_ok_o(clk_ok),
        .fault_o(fault),
        .retry_cnt_o(retry_cnt),
        .lol_cnt_o(lol_cnt),
        .state_o(state)
    );

    always #5 refclk = ~refclk;

    typedef struct {
        logic       rst;
        logic       lk;
        int         adv;
        logic [2:0] st;
        logic       pll;
        logic [2:0] dom;
        logic       ok;
        logic       flt;
        logic [2:0] rty;
    } vec_t;

    vec_t tbl[12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    function automatic logic [7:0] get(input int sel);
        return sel == 0 ? {5'd0, state} : sel == 1 ? {5'd0, dom_rst} : {5'd0, retry_cnt};
    endfunction

    task automatic wait_sig(input string name, input int sel, input logic [7:0] val, input int budget);
        int n;
        n = 0;
        while (get(sel) !== val && n < budget) begin
            step(1);
            n++;
        end
        check(name, get(sel), val);
    endtask

    int fall_t[3];
    logic [2:0] fall_r[3];
    int nfall;
    int fault_t;
    logic prev;

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 2, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[1]  = '{1'b0, 1'b0, 3, 3'd0, 1'b1, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[2]  = '{1'b0, 1'b0, 1, 3'd1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[3]  = '{1'b0, 1'b0, 3, 3'd1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[4]  = '{1'b0, 1'b1, 2, 3'd1, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[5]  = '{1'b0, 1'b1, 1, 3'd2, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[6]  = '{1'b0, 1'b1, 7, 3'd2, 1'b0, 3'd7, 1'b0, 1'b0, 3'd0};
        tbl[7]  = '{1'b0, 1'b1, 1, 3'd3, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0};
        tbl[8]  = '{1'b0, 1'b1, 1, 3'd3, 1'b0, 3'd6, 1'b0, 1'b0, 3'd0};
        tbl[9]  = '{1'b0, 1'b1, 1, 3'd3, 1'b0, 3'd4, 1'b0, 1'b0, 3'd0};
        tbl[10] = '{1'b0, 1'b1, 2, 3'd3, 1'b0, 3'd0, 1'b0, 1'b0, 3'd0};
        tbl[11] = '{1'b0, 1'b1, 1, 3'd4, 1'b0, 3'd0, 1'b1, 1'b0, 3'd0};
        for (int i = 0; i < 12; i++) begin
            rst = tbl[i].rst;
            pll_locked = tbl[i].lk;
            step(tbl[i].adv);
            check($sformatf("row%0d_state", i), state, tbl[i].st);
            check($sformatf("row%0d_pll_rst", i), pll_rst, tbl[i].pll);
            check($sformatf("row%0d_dom_rst", i), dom_rst, tbl[i].dom);
            check($sformatf("row%0d_clk_ok", i), clk_ok, tbl[i].ok);
            check($sformatf("row%0d_fault", i), fault, tbl[i].flt);
            check($sformatf("row%0d_retry", i), retry_cnt, tbl[i].rty);
        end
        check("reset_lol", lol_cnt, 0);

        pll_locked = 1'b0;
        step(2);
        check("run_loss_early_state", state, 4);
        check("run_loss_early_ok", clk_ok, 1);
        step(1);
        check("run_loss_state", state, 0);
        check("run_loss_dom", dom_rst, 7);
        check("run_loss_ok", clk_ok, 0);
        check("run_loss_lol", lol_cnt, 1);
        pll_locked = 1'b1;
        wait_sig("reseq_run", 0, 4, 100);
        check("reseq_ok", clk_ok, 1);

        pll_locked = 1'b0;
        step(3);
        check("glitch_lol", lol_cnt, 2);
        pll_locked = 1'b1;
        wait_sig("glitch_to_stable", 0, 2, 100);
        step(4);
        pll_locked = 1'b0;
        step(1);
        pll_locked = 1'b1;
        step(1);
        check("glitch_pre_state", state, 2);
        step(1);
        check("glitch_wait_state", state, 1);
        check("glitch_dom", dom_rst, 7);
        step(8);
        check("glitch_requal_state", state, 2);
        check("glitch_requal_dom", dom_rst, 7);
        step(1);
        check("glitch_release_state", state, 3);
        check("glitch_release_dom", dom_rst, 6);
        wait_sig("glitch_run", 0, 4, 100);

        pll_locked = 1'b0;
        step(3);
        check("rel_lol", lol_cnt, 3);
        wait_sig("rel_retry1", 2, 1, 100);
        check("rel_retry_state", state, 0);
        pll_locked = 1'b1;
        wait_sig("rel_dom110", 1, 6, 100);
        pll_locked = 1'b0;
        step(2);
        check("rel_loss_early", state, 3);
        step(1);
        check("rel_loss_state", state, 0);
        check("rel_loss_dom", dom_rst, 7);
        check("rel_loss_retry", retry_cnt, 1);
        pll_locked = 1'b1;
        wait_sig("rel_run", 0, 4, 100);

        for (int i = 4; i <= 300; i++) begin
            pll_locked = 1'b0;
            step(3);
            pll_locked = 1'b1;
            wait_sig("sat_run", 0, 4, 100);
            if (i == 254) check("lol_254", lol_cnt, 254);
        end
        check("lol_sat", lol_cnt, 255);

        rst = 1'b1;
        step(1);
        check("rst_run_state", state, 0);
        check("rst_run_pll", pll_rst, 1);
        check("rst_run_dom", dom_rst, 7);
        check("rst_run_lol", lol_cnt, 0);
        check("rst_run_ok", clk_ok, 0);
        rst = 1'b0;
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        check("relock_rp_state", state, 0);
        step(2);
        check("relock_rp_pll_hi", pll_rst, 1);
        step(1);
        check("relock_rp_pll_lo", pll_rst, 0);
        check("relock_rp_wait", state, 1);

        pll_locked = 1'b0;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        nfall = 0;
        fault_t = -1;
        prev = pll_rst;
        for (int c = 1; c <= 100 && fault_t < 0; c++) begin
            step(1);
            if (prev && !pll_rst && nfall < 3) begin
                fall_t[nfall] = c;
                fall_r[nfall] = retry_cnt;
                nfall++;
            end
            if (fault) fault_t = c;
            prev = pll_rst;
        end
        check("nolock_pulses", nfall, 3);
        for (int i = 0; i < 3 && i < nfall; i++) begin
            check($sformatf("nolock_fall%0d", i), fall_t[i], 4 + 24 * i);
            check($sformatf("nolock_retry%0d", i), fall_r[i], i);
        end
        check("nolock_fault_t", fault_t, 72);
        check("fault_state", state, 5);
        check("fault_pll", pll_rst, 1);
        check("fault_dom", dom_rst, 7);
        check("fault_retry", retry_cnt, 2);
        relock_req = 1'b1;
        step(1);
        relock_req = 1'b0;
        check("relock_fault", fault, 0);
        check("relock_state", state, 0);
        check("relock_retry", retry_cnt, 0);
        check("relock_pll", pll_rst, 1);
        check("relock_dom", dom_rst, 7);
        step(3);
        check("relock_pulse_hi", pll_rst, 1);
        step(1);
        check("relock_pulse_lo", pll_rst, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
